// File: rtl/eth_pkg.sv
// Shared Ethernet TX/RX definitions: serializer state encoding and preamble constants.
// Optional feature macro used by the serializer: MII_TX_PREAMBLE_EN.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_LO,
        ST_HI,
        ST_UNDR,
        ST_DRAIN,
        ST_IFG
    } tx_ser_state_t;

    localparam logic [3:0]  PREAMBLE_NIBBLE   = 4'h5;
    localparam logic [3:0]  SFD_NIBBLE        = 4'hD;
    localparam int unsigned PREAMBLE_NIBBLES  = 16;
    localparam int unsigned DEFAULT_IFG_BYTES = 12;

endpackage

// File: rtl/mii_ifg_timer.sv
// Inter-frame gap timer: load starts a LEN-cycle window, done_c flags its final cycle.
// Shared by the MII TX serializer and the RX side.
module mii_ifg_timer #(
    parameter int unsigned LEN = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_done_c
);

    localparam int unsigned W = (LEN == 0) ? 1 : $clog2(LEN + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= W'(LEN);
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done_c = (r_cnt <= W'(1));

endmodule

// File: rtl/mii_tx_nibble_ser.sv
// Byte-stream to 4-bit MII TX serializer (low nibble first) with IFG, underrun signalling and status counters.
// Define MII_TX_PREAMBLE_EN to have the block generate preamble/SFD itself.
module mii_tx_nibble_ser
    import eth_pkg::*;
#(
    parameter int unsigned IFG_BYTES = DEFAULT_IFG_BYTES,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [3:0]       mii_txd,
    output logic             mii_tx_en,
    output logic             mii_tx_er,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] underrun_cnt
);

    localparam int unsigned IFG_CYCLES = 2 * IFG_BYTES;

    if (IFG_BYTES == 0) begin : g_bad_ifg
        $error("mii_tx_nibble_ser: IFG_BYTES must be non-zero");
    end

    tx_ser_state_t    r_state;
    logic [7:0]       r_byte;
    logic             r_last;
    logic [3:0]       r_txd;
    logic             r_tx_en;
    logic             r_tx_er;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_underrun_cnt;
`ifdef MII_TX_PREAMBLE_EN
    localparam logic [4:0] PRE_LAST = 5'(PREAMBLE_NIBBLES);
    localparam logic [4:0] PRE_SFD  = 5'(PREAMBLE_NIBBLES - 1);
    logic [4:0]       r_pre_cnt;
`endif

    logic w_ready;
    logic w_xfer;
    logic w_ifg_load;
    logic w_ifg_done;

    // Ready depends only on the current state (and the latched last flag in HI).
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE:  w_ready = 1'b1;
            ST_HI:    w_ready = !r_last;
            ST_DRAIN: w_ready = 1'b1;
            default:  w_ready = 1'b0;
        endcase
    end

    assign w_xfer     = s_valid && w_ready;
    assign w_ifg_load = ((r_state == ST_HI) && r_last) ||
                        ((r_state == ST_DRAIN) && w_xfer && s_last);

    mii_ifg_timer #(
        .LEN (IFG_CYCLES)
    ) u_ifg_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_ifg_load),
        .i_en     (r_state == ST_IFG),
        .o_done_c (w_ifg_done)
    );

    // MII outputs are computed on the transition into the state that drives them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_byte         <= '0;
            r_last         <= 1'b0;
            r_txd          <= '0;
            r_tx_en        <= 1'b0;
            r_tx_er        <= 1'b0;
            r_frame_cnt    <= '0;
            r_underrun_cnt <= '0;
`ifdef MII_TX_PREAMBLE_EN
            r_pre_cnt      <= '0;
`endif
        end else begin
            r_txd   <= '0;
            r_tx_en <= 1'b0;
            r_tx_er <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_byte  <= s_data;
                        r_last  <= s_last;
                        r_tx_en <= 1'b1;
`ifdef MII_TX_PREAMBLE_EN
                        r_state   <= ST_PRE;
                        r_txd     <= PREAMBLE_NIBBLE;
                        r_pre_cnt <= 5'd1;
`else
                        r_state <= ST_LO;
                        r_txd   <= s_data[3:0];
`endif
                    end
                end
`ifdef MII_TX_PREAMBLE_EN
                ST_PRE: begin
                    r_tx_en <= 1'b1;
                    if (r_pre_cnt == PRE_LAST) begin
                        r_state <= ST_LO;
                        r_txd   <= r_byte[3:0];
                    end else begin
                        r_pre_cnt <= r_pre_cnt + 5'd1;
                        r_txd     <= (r_pre_cnt == PRE_SFD) ? SFD_NIBBLE : PREAMBLE_NIBBLE;
                    end
                end
`endif
                ST_LO: begin
                    r_state <= ST_HI;
                    r_txd   <= r_byte[7:4];
                    r_tx_en <= 1'b1;
                end
                ST_HI: begin
                    if (r_last) begin
                        r_state     <= ST_IFG;
                        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                    end else if (w_xfer) begin
                        r_state <= ST_LO;
                        r_byte  <= s_data;
                        r_last  <= s_last;
                        r_txd   <= s_data[3:0];
                        r_tx_en <= 1'b1;
                    end else begin
                        r_state <= ST_UNDR;
                        r_tx_en <= 1'b1;
                        r_tx_er <= 1'b1;
                    end
                end
                ST_UNDR: begin
                    r_state <= ST_DRAIN;
                    if (r_underrun_cnt != '1) begin
                        r_underrun_cnt <= r_underrun_cnt + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (w_xfer && s_last) begin
                        r_state <= ST_IFG;
                    end
                end
                ST_IFG: begin
                    if (w_ifg_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_ready      = w_ready && !rst;
    assign mii_txd      = r_txd;
    assign mii_tx_en    = r_tx_en;
    assign mii_tx_er    = r_tx_er;
    assign busy         = (r_state != ST_IDLE);
    assign frame_cnt    = r_frame_cnt;
    assign underrun_cnt = r_underrun_cnt;

endmodule
